// File: rtl/pipe_ctrl_unit_if.sv
// Bundle between the 5-stage datapath and pipe_ctrl_unit.
//   master : datapath side (drives the ID fields and ex_redirect, receives the
//            enables and the per-stage control fields)
//   slave  : control unit side (the reverse)
// Ports carried: id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
//   pc_write, ifid_write, ifid_flush, id_illegal, illegal_seen,
//   ex_* / mem_* / wb_* stage control fields.
interface pipe_ctrl_unit_if #(
  parameter int OPC_W = 7,
  parameter int RA_W  = 5
);
  logic             id_valid;
  logic [OPC_W-1:0] id_opcode;
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic [RA_W-1:0]  id_rd;
  logic             ex_redirect;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             id_illegal;
  logic             illegal_seen;

  logic             ex_valid;
  logic             ex_ALUSrc;
  logic             ex_Branch;
  logic [1:0]       ex_ALUOp;
  logic [1:0]       ex_JalType;
  logic [RA_W-1:0]  ex_rd;

  logic             mem_valid;
  logic             mem_MemRead;
  logic             mem_MemWrite;
  logic [RA_W-1:0]  mem_rd;

  logic             wb_valid;
  logic             wb_RegWrite;
  logic             wb_MemtoReg;
  logic [RA_W-1:0]  wb_rd;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
    input  pc_write, ifid_write, ifid_flush, id_illegal, illegal_seen,
    input  ex_valid, ex_ALUSrc, ex_Branch, ex_ALUOp, ex_JalType, ex_rd,
    input  mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
    input  wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
    output pc_write, ifid_write, ifid_flush, id_illegal, illegal_seen,
    output ex_valid, ex_ALUSrc, ex_Branch, ex_ALUOp, ex_JalType, ex_rd,
    output mem_valid, mem_MemRead, mem_MemWrite, mem_rd,
    output wb_valid, wb_RegWrite, wb_MemtoReg, wb_rd
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage datapath.
// Decodes the ID opcode, carries the control bundle through ID/EX, EX/MEM
// and MEM/WB, stalls on load-use hazards and squashes ID on EX redirects.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset (clears every stage to a bubble)
//   bus   pipe_ctrl_unit_if.slave: ID fields and ex_redirect in; PC/IF-ID
//         enables, id_illegal (combinational), illegal_seen (sticky) and the
//         ex_/mem_/wb_ stage control fields out.
module pipe_ctrl_unit #(
  parameter int OPC_W      = 7,
  parameter int RA_W       = 5,
  parameter int EN_IMM_ALU = 1,
  parameter int EN_HAZARD  = 1
) (
  input logic              clk,
  input logic              rst_n,
  pipe_ctrl_unit_if.slave  bus
);

  localparam logic [OPC_W-1:0] OPC_R     = OPC_W'(7'b0110011);
  localparam logic [OPC_W-1:0] OPC_LW    = OPC_W'(7'b0000011);
  localparam logic [OPC_W-1:0] OPC_SW    = OPC_W'(7'b0100011);
  localparam logic [OPC_W-1:0] OPC_BR    = OPC_W'(7'b1100011);
  localparam logic [OPC_W-1:0] OPC_JAL   = OPC_W'(7'b1101111);
  localparam logic [OPC_W-1:0] OPC_JALR  = OPC_W'(7'b1100111);
  localparam logic [OPC_W-1:0] OPC_IALU  = OPC_W'(7'b0010011);
  localparam logic [OPC_W-1:0] OPC_LUI   = OPC_W'(7'b0110111);
  localparam logic [OPC_W-1:0] OPC_AUIPC = OPC_W'(7'b0010111);

  // Decoded ID-stage controls
  logic       dec_legal_s, dec_use_rs1_s, dec_use_rs2_s;
  logic       dec_alusrc_s, dec_branch_s, dec_memread_s, dec_memwrite_s;
  logic       dec_regwrite_s, dec_memtoreg_s;
  logic [1:0] dec_aluop_s, dec_jal_s;

  // Hazard / steering
  logic stall_s, load_s, id_illegal_s;
  logic pc_write_s, ifid_write_s, ifid_flush_s;

  // Stage registers
  logic            ex_valid_r, ex_alusrc_r, ex_branch_r, ex_memread_r;
  logic            ex_memwrite_r, ex_regwrite_r, ex_memtoreg_r;
  logic [1:0]      ex_aluop_r, ex_jal_r;
  logic [RA_W-1:0] ex_rd_r;
  logic            mem_valid_r, mem_memread_r, mem_memwrite_r;
  logic            mem_regwrite_r, mem_memtoreg_r;
  logic [RA_W-1:0] mem_rd_r;
  logic            wb_valid_r, wb_regwrite_r, wb_memtoreg_r;
  logic [RA_W-1:0] wb_rd_r;
  logic            illegal_seen_r;

  // Opcode decode into the control bundle and register-usage flags
  always_comb begin
    dec_legal_s    = 1'b0;
    dec_use_rs1_s  = 1'b0;
    dec_use_rs2_s  = 1'b0;
    dec_alusrc_s   = 1'b0;
    dec_branch_s   = 1'b0;
    dec_memread_s  = 1'b0;
    dec_memwrite_s = 1'b0;
    dec_regwrite_s = 1'b0;
    dec_memtoreg_s = 1'b0;
    dec_aluop_s    = 2'b00;
    dec_jal_s      = 2'b00;
    case (bus.id_opcode)
      OPC_R: begin
        dec_legal_s = 1'b1; dec_use_rs1_s = 1'b1; dec_use_rs2_s = 1'b1;
        dec_regwrite_s = 1'b1; dec_aluop_s = 2'b10;
      end
      OPC_LW: begin
        dec_legal_s = 1'b1; dec_use_rs1_s = 1'b1;
        dec_alusrc_s = 1'b1; dec_memread_s = 1'b1; dec_memtoreg_s = 1'b1;
        dec_regwrite_s = 1'b1;
      end
      OPC_SW: begin
        dec_legal_s = 1'b1; dec_use_rs1_s = 1'b1; dec_use_rs2_s = 1'b1;
        dec_alusrc_s = 1'b1; dec_memwrite_s = 1'b1;
      end
      OPC_BR: begin
        dec_legal_s = 1'b1; dec_use_rs1_s = 1'b1; dec_use_rs2_s = 1'b1;
        dec_branch_s = 1'b1; dec_aluop_s = 2'b01;
      end
      OPC_JAL: begin
        dec_legal_s = 1'b1; dec_regwrite_s = 1'b1;
        dec_jal_s = 2'b10; dec_aluop_s = 2'b10;
      end
      OPC_JALR: begin
        dec_legal_s = 1'b1; dec_use_rs1_s = 1'b1; dec_alusrc_s = 1'b1;
        dec_regwrite_s = 1'b1; dec_jal_s = 2'b01; dec_aluop_s = 2'b10;
      end
      OPC_IALU: begin
        if (EN_IMM_ALU != 0) begin
          dec_legal_s = 1'b1; dec_use_rs1_s = 1'b1; dec_alusrc_s = 1'b1;
          dec_regwrite_s = 1'b1; dec_aluop_s = 2'b11;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        if (EN_IMM_ALU != 0) begin
          dec_legal_s = 1'b1; dec_alusrc_s = 1'b1; dec_regwrite_s = 1'b1;
        end else begin
          dec_legal_s = 1'b0;
        end
      end
      default: begin
        dec_legal_s = 1'b0;
      end
    endcase
  end

  // Load-use detection and PC/IF-ID steering; redirect beats stall
  always_comb begin
    id_illegal_s = bus.id_valid & ~dec_legal_s;
    if (EN_HAZARD != 0) begin
      stall_s = bus.id_valid & ex_valid_r & ex_memread_r &
                (ex_rd_r != {RA_W{1'b0}}) &
                ((dec_use_rs1_s & (ex_rd_r == bus.id_rs1)) |
                 (dec_use_rs2_s & (ex_rd_r == bus.id_rs2)));
    end else begin
      stall_s = 1'b0;
    end
    if (bus.ex_redirect) begin
      pc_write_s = 1'b1; ifid_write_s = 1'b1; ifid_flush_s = 1'b1;
      load_s     = 1'b0;
    end else if (stall_s) begin
      pc_write_s = 1'b0; ifid_write_s = 1'b0; ifid_flush_s = 1'b0;
      load_s     = 1'b0;
    end else begin
      pc_write_s = 1'b1; ifid_write_s = 1'b1; ifid_flush_s = 1'b0;
      // Invalid or illegal ID slots enter EX as bubbles
      load_s     = bus.id_valid & dec_legal_s;
    end
  end

  // ID/EX register: decoded bundle or bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0; ex_alusrc_r <= 1'b0; ex_branch_r <= 1'b0;
      ex_memread_r <= 1'b0; ex_memwrite_r <= 1'b0; ex_regwrite_r <= 1'b0;
      ex_memtoreg_r <= 1'b0; ex_aluop_r <= 2'b00; ex_jal_r <= 2'b00;
      ex_rd_r <= {RA_W{1'b0}};
    end else if (load_s) begin
      ex_valid_r <= 1'b1; ex_alusrc_r <= dec_alusrc_s;
      ex_branch_r <= dec_branch_s; ex_memread_r <= dec_memread_s;
      ex_memwrite_r <= dec_memwrite_s; ex_regwrite_r <= dec_regwrite_s;
      ex_memtoreg_r <= dec_memtoreg_s; ex_aluop_r <= dec_aluop_s;
      ex_jal_r <= dec_jal_s; ex_rd_r <= bus.id_rd;
    end else begin
      ex_valid_r <= 1'b0; ex_alusrc_r <= 1'b0; ex_branch_r <= 1'b0;
      ex_memread_r <= 1'b0; ex_memwrite_r <= 1'b0; ex_regwrite_r <= 1'b0;
      ex_memtoreg_r <= 1'b0; ex_aluop_r <= 2'b00; ex_jal_r <= 2'b00;
      ex_rd_r <= {RA_W{1'b0}};
    end
  end

  // EX/MEM and MEM/WB registers advance every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r <= 1'b0; mem_memread_r <= 1'b0; mem_memwrite_r <= 1'b0;
      mem_regwrite_r <= 1'b0; mem_memtoreg_r <= 1'b0; mem_rd_r <= {RA_W{1'b0}};
      wb_valid_r <= 1'b0; wb_regwrite_r <= 1'b0; wb_memtoreg_r <= 1'b0;
      wb_rd_r <= {RA_W{1'b0}};
    end else begin
      mem_valid_r <= ex_valid_r; mem_memread_r <= ex_memread_r;
      mem_memwrite_r <= ex_memwrite_r; mem_regwrite_r <= ex_regwrite_r;
      mem_memtoreg_r <= ex_memtoreg_r; mem_rd_r <= ex_rd_r;
      wb_valid_r <= mem_valid_r; wb_regwrite_r <= mem_regwrite_r;
      wb_memtoreg_r <= mem_memtoreg_r; wb_rd_r <= mem_rd_r;
    end
  end

  // Sticky illegal flag; a squashed illegal instruction does not count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen_r <= 1'b0;
    end else if (id_illegal_s & ~bus.ex_redirect) begin
      illegal_seen_r <= 1'b1;
    end else begin
      illegal_seen_r <= illegal_seen_r;
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.ifid_write   = ifid_write_s;
  assign bus.ifid_flush   = ifid_flush_s;
  assign bus.id_illegal   = id_illegal_s;
  assign bus.illegal_seen = illegal_seen_r;
  assign bus.ex_valid     = ex_valid_r;
  assign bus.ex_ALUSrc    = ex_alusrc_r;
  assign bus.ex_Branch    = ex_branch_r;
  assign bus.ex_ALUOp     = ex_aluop_r;
  assign bus.ex_JalType   = ex_jal_r;
  assign bus.ex_rd        = ex_rd_r;
  assign bus.mem_valid    = mem_valid_r;
  assign bus.mem_MemRead  = mem_memread_r;
  assign bus.mem_MemWrite = mem_memwrite_r;
  assign bus.mem_rd       = mem_rd_r;
  assign bus.wb_valid     = wb_valid_r;
  assign bus.wb_RegWrite  = wb_regwrite_r;
  assign bus.wb_MemtoReg  = wb_memtoreg_r;
  assign bus.wb_rd        = wb_rd_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit. Two instances share stimulus:
// inst 0 with all features on, inst 1 with EN_IMM_ALU=0 and EN_HAZARD=0.
// A reference model keeps a 3-entry array of in-flight instruction records
// (EX, MEM, WB) and shifts it once per clock.
module tb_pipe_ctrl_unit;

  typedef struct packed {
    logic       v, alusrc, branch, memread, memwrite, regwrite, memtoreg;
    logic [1:0] aluop, jal;
    logic [4:0] rd;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ctl_t st [2][3];
  bit   seen [2];
  bit   last_stall = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_unit_if #(.OPC_W(7), .RA_W(5)) bus0 ();
  pipe_ctrl_unit_if #(.OPC_W(7), .RA_W(5)) bus1 ();

  pipe_ctrl_unit #(.OPC_W(7), .RA_W(5), .EN_IMM_ALU(1), .EN_HAZARD(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  pipe_ctrl_unit #(.OPC_W(7), .RA_W(5), .EN_IMM_ALU(0), .EN_HAZARD(0))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  logic [3:0]  comb_o [2];
  logic        seen_o [2];
  logic [11:0] ex_o [2];
  logic [7:0]  mem_o [2];
  logic [7:0]  wb_o [2];

  assign comb_o[0] = {bus0.pc_write, bus0.ifid_write, bus0.ifid_flush, bus0.id_illegal};
  assign comb_o[1] = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.id_illegal};
  assign seen_o[0] = bus0.illegal_seen;
  assign seen_o[1] = bus1.illegal_seen;
  assign ex_o[0] = {bus0.ex_valid, bus0.ex_ALUSrc, bus0.ex_Branch, bus0.ex_ALUOp, bus0.ex_JalType, bus0.ex_rd};
  assign ex_o[1] = {bus1.ex_valid, bus1.ex_ALUSrc, bus1.ex_Branch, bus1.ex_ALUOp, bus1.ex_JalType, bus1.ex_rd};
  assign mem_o[0] = {bus0.mem_valid, bus0.mem_MemRead, bus0.mem_MemWrite, bus0.mem_rd};
  assign mem_o[1] = {bus1.mem_valid, bus1.mem_MemRead, bus1.mem_MemWrite, bus1.mem_rd};
  assign wb_o[0] = {bus0.wb_valid, bus0.wb_RegWrite, bus0.wb_MemtoReg, bus0.wb_rd};
  assign wb_o[1] = {bus1.wb_valid, bus1.wb_RegWrite, bus1.wb_MemtoReg, bus1.wb_rd};

  logic [6:0] opc_pool [12] = '{7'b0110011, 7'b0000011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0010011,
                                7'b0110111, 7'b0010111, 7'b1111111, 7'b0001111};

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Instruction-class table: control bundle and which sources are read.
  function automatic ctl_t model_decode(input logic [6:0] opc, input bit en_imm,
                                        output bit legal, output bit u1, output bit u2);
    ctl_t c = '0;
    legal = 1'b1; u1 = 1'b0; u2 = 1'b0;
    case (opc)
      7'b0110011: begin c.regwrite = 1; c.aluop = 2'b10; u1 = 1; u2 = 1; end
      7'b0000011: begin c.alusrc = 1; c.memread = 1; c.memtoreg = 1; c.regwrite = 1; u1 = 1; end
      7'b0100011: begin c.alusrc = 1; c.memwrite = 1; u1 = 1; u2 = 1; end
      7'b1100011: begin c.branch = 1; c.aluop = 2'b01; u1 = 1; u2 = 1; end
      7'b1101111: begin c.regwrite = 1; c.jal = 2'b10; c.aluop = 2'b10; end
      7'b1100111: begin c.alusrc = 1; c.regwrite = 1; c.jal = 2'b01; c.aluop = 2'b10; u1 = 1; end
      7'b0010011: if (en_imm) begin c.alusrc = 1; c.regwrite = 1; c.aluop = 2'b11; u1 = 1; end
                  else legal = 1'b0;
      7'b0110111, 7'b0010111: if (en_imm) begin c.alusrc = 1; c.regwrite = 1; end
                  else legal = 1'b0;
      default: legal = 1'b0;
    endcase
    return c;
  endfunction

  task automatic drive(input logic v, input logic [6:0] opc, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rdd, input logic redir);
    bus0.id_valid = v; bus0.id_opcode = opc; bus0.id_rs1 = r1; bus0.id_rs2 = r2;
    bus0.id_rd = rdd; bus0.ex_redirect = redir;
    bus1.id_valid = v; bus1.id_opcode = opc; bus1.id_rs1 = r1; bus1.id_rs2 = r2;
    bus1.id_rd = rdd; bus1.ex_redirect = redir;
  endtask

  // One clock: drive, check on the falling edge, advance the model.
  task automatic step(input logic v, input logic [6:0] opc, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rdd, input logic redir);
    drive(v, opc, r1, r2, rdd, redir);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ctl_t d, ex;
      bit lg, u1, u2, ill, stall;
      logic [2:0] en;
      ex = st[i][0];
      d = model_decode(opc, (i == 0), lg, u1, u2);
      ill = v && !lg;
      stall = (i == 0) && v && ex.v && ex.memread && (ex.rd != 5'd0) &&
              ((u1 && ex.rd == r1) || (u2 && ex.rd == r2));
      en = redir ? 3'b111 : (stall ? 3'b000 : 3'b110);
      check_val($sformatf("ctl%0d", i), {28'd0, comb_o[i]}, {28'd0, en, ill});
      check_val($sformatf("seen%0d", i), {31'd0, seen_o[i]}, {31'd0, seen[i]});
      check_val($sformatf("ex%0d", i), {20'd0, ex_o[i]},
                {20'd0, ex.v, ex.alusrc, ex.branch, ex.aluop, ex.jal, ex.rd});
      check_val($sformatf("mem%0d", i), {24'd0, mem_o[i]},
                {24'd0, st[i][1].v, st[i][1].memread, st[i][1].memwrite, st[i][1].rd});
      check_val($sformatf("wb%0d", i), {24'd0, wb_o[i]},
                {24'd0, st[i][2].v, st[i][2].regwrite, st[i][2].memtoreg, st[i][2].rd});
      st[i][2] = st[i][1];
      st[i][1] = st[i][0];
      if (v && lg && !stall && !redir) begin
        d.v = 1'b1; d.rd = rdd; st[i][0] = d;
      end else begin
        st[i][0] = '0;
      end
      if (ill && !redir) seen[i] = 1'b1;
      if (i == 0) last_stall = stall && !redir;
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check that everything clears at once.
  task automatic do_reset();
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("rst_ctl%0d", i), {28'd0, comb_o[i]}, 32'h0000000C);
      check_val($sformatf("rst_seen%0d", i), {31'd0, seen_o[i]}, 32'd0);
      check_val($sformatf("rst_ex%0d", i), {20'd0, ex_o[i]}, 32'd0);
      check_val($sformatf("rst_mem%0d", i), {24'd0, mem_o[i]}, 32'd0);
      check_val($sformatf("rst_wb%0d", i), {24'd0, wb_o[i]}, 32'd0);
      for (int s = 0; s < 3; s++) st[i][s] = '0;
      seen[i] = 1'b0;
    end
    last_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LW = 7'b0000011, ADD = 7'b0110011, JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111, JALR = 7'b1100111, IALU = 7'b0010011;

  initial begin
    logic       v, redir;
    logic [6:0] opc;
    logic [4:0] r1, r2, rdd;
    drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Load-use: stall once, ADD held then issued, then drain
    step(1, LW, 5'd1, 5'd0, 5'd5, 0);
    step(1, ADD, 5'd5, 5'd2, 5'd6, 0);
    step(1, ADD, 5'd5, 5'd2, 5'd6, 0);
    repeat (3) step(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    // No stall: load to x0, or consumer reads no registers
    step(1, LW, 5'd1, 5'd0, 5'd0, 0);
    step(1, ADD, 5'd0, 5'd0, 5'd7, 0);
    step(1, LW, 5'd1, 5'd0, 5'd5, 0);
    step(1, JAL, 5'd5, 5'd5, 5'd1, 0);
    step(1, LW, 5'd1, 5'd0, 5'd5, 0);
    step(1, LUI, 5'd5, 5'd5, 5'd2, 0);
    // Stall condition together with redirect
    step(1, LW, 5'd1, 5'd0, 5'd5, 0);
    step(1, ADD, 5'd5, 5'd5, 5'd3, 1);
    // JALR in EX redirects; the squashed instruction never appears
    step(1, JALR, 5'd2, 5'd0, 5'd1, 0);
    step(1, ADD, 5'd1, 5'd1, 5'd4, 1);
    repeat (3) step(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    // Illegal opcodes (I-ALU illegal only in inst 1)
    step(1, 7'b1111111, 5'd0, 5'd0, 5'd1, 0);
    step(1, IALU, 5'd1, 5'd0, 5'd2, 0);
    step(1, ADD, 5'd1, 5'd2, 5'd3, 0);
    step(1, LW, 5'd1, 5'd0, 5'd4, 0);
    do_reset();
    // Squashed illegal leaves the sticky flag clear
    step(1, 7'b1111111, 5'd0, 5'd0, 5'd1, 1);
    step(0, 7'd0, 5'd0, 5'd0, 5'd0, 0);

    v = 0; redir = 0; opc = 7'd0; r1 = 5'd0; r2 = 5'd0; rdd = 5'd0;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      if (!last_stall) begin
        v   = ($urandom_range(0, 9) != 0);
        opc = opc_pool[$urandom_range(0, 11)];
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rdd = 5'($urandom_range(0, 3));
      end
      redir = ($urandom_range(0, 6) == 0);
      step(v, opc, r1, r2, rdd, redir);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into the control bundle, carries it through the ID/EX, EX/MEM and MEM/WB registers, and detects load-use hazards (stall) and EX-stage redirects (flush).
- Sits beside the 5-stage datapath. Drives the PC/IF-ID write enables and the per-stage control fields.

Parameters:
- OPC_W, 7, opcode field width.
- RA_W, 5, register address width.
- EN_IMM_ALU, 1, when 1 decode I-type ALU (0010011), LUI (0110111) and AUIPC (0010111); when 0 these opcodes are illegal.
- EN_HAZARD, 1, when 0 load-use detection is disabled (stall never asserted).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  OPC_W  opcode of the ID instruction.
- id_rs1, id_rs2, id_rd  in  RA_W  register fields of the ID instruction.
- ex_redirect  in  1  branch taken or jump resolved for the instruction in EX.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to a bubble.
- id_illegal  out  1  combinational: id_valid and opcode not decodable.
- illegal_seen  out  1  sticky registered illegal flag.
- ex_valid, ex_ALUSrc, ex_Branch  out  1 each.
- ex_ALUOp  out  2.
- ex_JalType  out  2  {JAL, JALR}.
- ex_rd  out  RA_W.
- mem_valid, mem_MemRead, mem_MemWrite  out  1 each.
- mem_rd  out  RA_W.
- wb_valid, wb_RegWrite, wb_MemtoReg  out  1 each.
- wb_rd  out  RA_W.

Behaviour:
- Decode (combinational on id_opcode):
  - R 0110011: RegWrite, ALUOp=10.
  - LW 0000011: ALUSrc, MemRead, MemtoReg, RegWrite, ALUOp=00.
  - SW 0100011: ALUSrc, MemWrite, ALUOp=00.
  - BR 1100011: Branch, ALUOp=01.
  - JAL 1101111: RegWrite, JalType=10, ALUOp=10.
  - JALR 1100111: ALUSrc, RegWrite, JalType=01, ALUOp=10.
  - I-ALU: ALUSrc, RegWrite, ALUOp=11.
  - LUI/AUIPC: ALUSrc, RegWrite, ALUOp=00.
  - Any other opcode: all controls 0, id_illegal=id_valid.
- Register usage:
  - rs1 used by R, I-ALU, LW, SW, BR, JALR.
  - rs2 used by R, SW, BR.
  - LUI, AUIPC and JAL use neither.
- Load-use stall (when EN_HAZARD=1): stall = id_valid & ex_valid & ex_MemRead_reg & ex_rd≠0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- Redirect priority: ex_redirect=1 overrides stall.
  - pc_write=1, ifid_write=1, ifid_flush=1.
  - ID/EX loads a bubble (the ID instruction is squashed).
  - The EX instruction itself proceeds normally (JAL/JALR still write rd).
- Stall without redirect:
  - pc_write=0, ifid_write=0, ifid_flush=0.
  - ID/EX loads a bubble; ID holds, and the decode is re-evaluated next cycle.
- Normal cycle: pc_write=1, ifid_write=1, ifid_flush=0; ID/EX loads the decoded bundle with valid=id_valid & ~id_illegal.
- Bubble definition: valid=0, all control bits 0, rd=0.
- Illegal instruction: enters ID/EX as a bubble and sets illegal_seen on the next edge. illegal_seen is cleared only by reset. A squashed illegal instruction (same cycle as ex_redirect) does not set illegal_seen.
- Pipeline advance: EX/MEM and MEM/WB load unconditionally every cycle (no downstream stall). Latency from ID decode to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- id_rd = 0 with RegWrite is passed through unchanged; the register file ignores x0.
- Reset (async assert, sync-to-clk deassert handled upstream):
  - All stage registers become bubbles and illegal_seen=0.
  - Combinational outputs follow inputs: with id_valid=0, pc_write=1, ifid_write=1, ifid_flush=0.
  - Reset asserted mid-stall or mid-redirect clears all state immediately; no pending stall survives reset.

Test Plan:
- LW x5 (opcode 0000011, rd=5) then ADD rs1=5 next cycle: stall=1 for exactly 1 cycle (pc_write=0, ifid_write=0); ex_valid=0 bubble; ADD reaches EX one cycle later with ALUOp=10; wb_rd=5 with wb_MemtoReg=1 three cycles after LW decode.
- LW x0 followed by ADD rs1=0: no stall. LW x5 followed by JAL or LUI: no stall, because those opcodes do not use rs1 or rs2.
- Stall condition and ex_redirect=1 in the same cycle: pc_write=1, ifid_flush=1, next ex_valid=0.
- JALR in EX with ex_redirect=1: the squashed instruction never appears; JALR shows wb_RegWrite=1 two cycles later.
- Opcode 1111111 with id_valid=1: id_illegal=1 same cycle, ex_valid=0 next cycle, illegal_seen=1 thereafter until rst_n=0. With EN_IMM_ALU=0, opcode 0010011 behaves identically.
- rst_n pulled low while the pipeline is full: all valid/control outputs read 0 immediately without a clock edge; illegal_seen=0.
